// File: rtl/prbs9_pkg.sv
// ----------------------------------------------------------------------------
// prbs9_pkg
// Shared constants for the PRBS9 BER controller. The polynomial is
// x^9 + x^5 + 1 and symbols are sent LSB first. The package also holds the
// controller state encoding and the predictor helper.
// No ports (package).
// ----------------------------------------------------------------------------
package prbs9_pkg;

    localparam int         PRBS9_LEN   = 9;
    localparam int         PRBS9_TAP_A = 0;
    localparam int         PRBS9_TAP_B = 4;
    localparam logic [8:0] PRBS9_SEED  = 9'b110101010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GRST = 3'd1,
        ST_FILL = 3'd2,
        ST_SYNC = 3'd3,
        ST_RUN  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // hist[0] is the oldest of the last nine symbols, so the next symbol of
    // the sequence is s[n+9] = s[n] ^ s[n+4].
    function automatic logic prbs9_predict(input logic [PRBS9_LEN-1:0] hist);
        return hist[PRBS9_TAP_A] ^ hist[PRBS9_TAP_B];
    endfunction

endpackage

// File: rtl/prbs9_ber_ctrl_if.sv
// ----------------------------------------------------------------------------
// prbs9_ber_ctrl_if
// Control and status bundle of the PRBS9 BER controller. Signal names carry
// the direction as seen from the controller.
//   i_start, i_abort, i_nsym : test control from the register side
//   i_rx_bit                 : received symbol from the channel model
//   o_gen_rst, o_valid       : drive the tx PRBS9 generator
//   o_busy .. o_sym_cnt      : status
// Modports: slave = controller, master = driver of controls / consumer.
// ----------------------------------------------------------------------------
interface prbs9_ber_ctrl_if #(
    parameter int NSYM_W = 16,
    parameter int ERR_W  = 16
);
    logic              i_start;
    logic              i_abort;
    logic [NSYM_W-1:0] i_nsym;
    logic              i_rx_bit;
    logic              o_gen_rst;
    logic              o_valid;
    logic              o_busy;
    logic              o_locked;
    logic              o_done;
    logic              o_sync_fail;
    logic [ERR_W-1:0]  o_err_cnt;
    logic [NSYM_W-1:0] o_sym_cnt;

    modport slave (
        input  i_start, i_abort, i_nsym, i_rx_bit,
        output o_gen_rst, o_valid, o_busy, o_locked, o_done, o_sync_fail,
               o_err_cnt, o_sym_cnt
    );

    modport master (
        output i_start, i_abort, i_nsym, i_rx_bit,
        input  o_gen_rst, o_valid, o_busy, o_locked, o_done, o_sync_fail,
               o_err_cnt, o_sym_cnt
    );
endinterface

// File: rtl/prbs9_sync_check.sv
// ----------------------------------------------------------------------------
// prbs9_sync_check
// Nine-symbol history of the received stream plus the PRBS9 predictor.
//   clk, i_rst   : clock, asynchronous active-high reset
//   i_clr        : clear the history (new test)
//   i_shift      : symbol tick, shift i_rx_bit into the history
//   i_rx_bit     : received symbol
//   o_match      : prediction from the history equals i_rx_bit
//   o_hist_zero  : history is all zeros (no valid PRBS state to lock on)
// ----------------------------------------------------------------------------
module prbs9_sync_check
    import prbs9_pkg::*;
(
    input  logic clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_shift,
    input  logic i_rx_bit,
    output logic o_match,
    output logic o_hist_zero
);

    logic [PRBS9_LEN-1:0] r_hist;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_hist <= '0;
        end else if (i_clr) begin
            r_hist <= '0;
        end else if (i_shift) begin
            r_hist <= {i_rx_bit, r_hist[PRBS9_LEN-1:1]};
        end
    end

    assign o_match     = (prbs9_predict(r_hist) == i_rx_bit);
    assign o_hist_zero = (r_hist == '0);

endmodule

// File: rtl/prbs9_ber_ctrl.sv
// ----------------------------------------------------------------------------
// prbs9_ber_ctrl
// BER test controller: resets the tx PRBS9 generator, strobes it once every
// DIV clocks, self-synchronises a local predictor to the received stream and
// counts symbol errors over a window of i_nsym symbols.
//   clk   : clock
//   i_rst : asynchronous active-high reset
//   bus   : prbs9_ber_ctrl_if.slave (control, rx symbol, generator strobes,
//           status and counters)
// Optional build macro PRBS9_SYNC_TIMEOUT_EN: when defined, SYNC gives up
// after SYNC_TMO ticks without lock and finishes with o_sync_fail=1. When
// undefined, SYNC waits indefinitely and o_sync_fail is constant 0.
// A single channel error is counted three times in RUN because the wrong bit
// stays in the history and spoils the predictions that use taps 4 and 0.
// ----------------------------------------------------------------------------
module prbs9_ber_ctrl
    import prbs9_pkg::*;
#(
    parameter int DIV      = 4,
    parameter int NSYM_W   = 16,
    parameter int ERR_W    = 16,
    parameter int SYNC_LEN = 16,
    parameter int SYNC_TMO = 1024
) (
    input  logic            clk,
    input  logic            i_rst,
    prbs9_ber_ctrl_if.slave bus
);

    localparam int               DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [7:0]       SYNC_LAST = 8'(SYNC_LEN - 1);
    localparam logic [3:0]       FILL_LAST = 4'(PRBS9_LEN - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [DIV_W-1:0]  r_div;
    logic              r_valid;
    logic [3:0]        r_fill;
    logic [7:0]        r_match;
    logic [NSYM_W-1:0] r_nsym;
    logic [NSYM_W-1:0] r_sym_cnt;
    logic [ERR_W-1:0]  r_err_cnt;

    logic w_start_ok;
    logic w_tick;
    logic w_cur_active;
    logic w_next_active;
    logic w_match;
    logic w_hist_zero;
    logic w_good;
    logic w_tmo;

    assign w_start_ok    = bus.i_start && !bus.i_abort &&
                           (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_cur_active  = (r_state == ST_FILL) || (r_state == ST_SYNC) ||
                           (r_state == ST_RUN);
    assign w_next_active = (w_state_next == ST_FILL) || (w_state_next == ST_SYNC) ||
                           (w_state_next == ST_RUN);
    // r_valid is only set while staying in an active state, so it doubles as
    // the symbol tick for the checker.
    assign w_tick        = r_valid;
    assign w_good        = w_match && !w_hist_zero;

    prbs9_sync_check u_sync_check (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_clr       (w_start_ok),
        .i_shift     (w_tick),
        .i_rx_bit    (bus.i_rx_bit),
        .o_match     (w_match),
        .o_hist_zero (w_hist_zero)
    );

`ifdef PRBS9_SYNC_TIMEOUT_EN
    localparam int TMO_W = $clog2(SYNC_TMO + 1);

    logic [TMO_W-1:0] r_tmo;
    logic             r_sync_fail;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmo       <= '0;
            r_sync_fail <= 1'b0;
        end else begin
            if (r_state != ST_SYNC) begin
                r_tmo <= '0;
            end else if (w_tick) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_start_ok) begin
                r_sync_fail <= 1'b0;
            end else if (r_state == ST_SYNC && w_state_next == ST_DONE) begin
                r_sync_fail <= 1'b1;
            end
        end
    end

    assign w_tmo           = w_tick && (r_tmo == TMO_W'(SYNC_TMO - 1));
    assign bus.o_sync_fail = r_sync_fail;
`else
    assign w_tmo           = 1'b0;
    assign bus.o_sync_fail = 1'b0;
`endif

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.i_abort && r_state != ST_IDLE) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (w_start_ok) w_state_next = ST_GRST;
                ST_GRST:          w_state_next = ST_FILL;
                ST_FILL:          if (w_tick && r_fill == FILL_LAST) w_state_next = ST_SYNC;
                ST_SYNC: begin
                    if (w_tick && w_good && r_match == SYNC_LAST) begin
                        w_state_next = ST_RUN;
                    end else if (w_tmo) begin
                        w_state_next = ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (r_nsym == '0) begin
                        w_state_next = ST_DONE;
                    end else if (w_tick && (r_sym_cnt + 1'b1) == r_nsym) begin
                        w_state_next = ST_DONE;
                    end
                end
                default:          w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_div     <= '0;
            r_valid   <= 1'b0;
            r_fill    <= '0;
            r_match   <= '0;
            r_nsym    <= '0;
            r_sym_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            // The divider only runs while the controller stays in an active
            // state; any exit (abort, DONE) drops the strobe on the same edge.
            if (w_cur_active && w_next_active) begin
                r_div   <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
                r_valid <= (r_div == DIV_LAST);
            end else begin
                r_div   <= '0;
                r_valid <= 1'b0;
            end

            if (w_start_ok) begin
                r_nsym    <= bus.i_nsym;
                r_fill    <= '0;
                r_match   <= '0;
                r_sym_cnt <= '0;
                r_err_cnt <= '0;
            end

            if (r_state == ST_FILL && w_tick) begin
                r_fill <= r_fill + 1'b1;
            end

            if (r_state == ST_SYNC && w_tick) begin
                r_match <= w_good ? r_match + 1'b1 : '0;
            end

            if (r_state == ST_RUN && w_tick && r_nsym != '0 && !bus.i_abort) begin
                r_sym_cnt <= r_sym_cnt + 1'b1;
                if (!w_match && r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.o_gen_rst = (r_state == ST_GRST);
    assign bus.o_valid   = r_valid;
    assign bus.o_busy    = w_cur_active || (r_state == ST_GRST);
    assign bus.o_locked  = (r_state == ST_RUN);
    assign bus.o_done    = (r_state == ST_DONE);
    assign bus.o_err_cnt = r_err_cnt;
    assign bus.o_sym_cnt = r_sym_cnt;

endmodule

// File: tb/tb_prbs9_ber_ctrl.sv
// ----------------------------------------------------------------------------
// tb_prbs9_ber_ctrl
// Directed bench for prbs9_ber_ctrl. Instance A uses DIV=4, instance B DIV=1.
// Each instance is looped back through a local PRBS9 generator model
// (x^9+x^5+1, seed 9'b110101010, output bit 0, shift on o_valid).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prbs9_ber_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prbs9_ber_ctrl_if #(.NSYM_W(16), .ERR_W(16)) bus_a ();
    prbs9_ber_ctrl_if #(.NSYM_W(16), .ERR_W(16)) bus_b ();

    prbs9_ber_ctrl #(.DIV(4), .NSYM_W(16), .ERR_W(16), .SYNC_LEN(16), .SYNC_TMO(1024))
        u_dut_a (.clk(clk), .i_rst(rst), .bus(bus_a));
    prbs9_ber_ctrl #(.DIV(1), .NSYM_W(16), .ERR_W(16), .SYNC_LEN(16), .SYNC_TMO(1024))
        u_dut_b (.clk(clk), .i_rst(rst), .bus(bus_b));

    // ---------------- generator models ----------------
    logic [8:0] gen_a = 9'b110101010;
    logic [8:0] gen_b = 9'b110101010;
    logic       stuck_a  = 1'b0;
    logic       inject_a = 1'b0;

    always @(posedge clk) begin
        if (bus_a.o_gen_rst)    gen_a <= 9'b110101010;
        else if (bus_a.o_valid) gen_a <= {gen_a[0] ^ gen_a[4], gen_a[8:1]};
        if (bus_b.o_gen_rst)    gen_b <= 9'b110101010;
        else if (bus_b.o_valid) gen_b <= {gen_b[0] ^ gen_b[4], gen_b[8:1]};
    end

    // One corrupted channel symbol: the one sampled while sym_cnt reads 40.
    assign bus_a.i_rx_bit = stuck_a ? 1'b0 :
        (gen_a[0] ^ (inject_a && bus_a.o_locked && bus_a.o_valid && bus_a.o_sym_cnt == 16'd40));
    assign bus_b.i_rx_bit = gen_b[0];

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // ---------------- instance A helpers ----------------
    int w_first_valid, w_gen_rst, w_pre_lock, w_locked_valid;
    bit w_done_seen, w_aborted;

    // Pulse i_start for one clock; returns at the negedge after the accept edge.
    task automatic start_a(input logic [15:0] nsym);
        @(negedge clk);
        bus_a.i_nsym  = nsym;
        bus_a.i_start = 1'b1;
        @(negedge clk);
        bus_a.i_start = 1'b0;
    endtask

    // Samples A on negedges (k=1 is the first negedge after the accept edge)
    // until DONE, until an abort is issued at RUN symbol abort_sym, or until
    // max_cyc cycles have passed.
    task automatic watch_a(input int max_cyc, input int abort_sym);
        int k;
        k = 1;
        w_first_valid = -1; w_gen_rst = 0; w_pre_lock = 0; w_locked_valid = 0;
        w_done_seen = 1'b0; w_aborted = 1'b0;
        while (k <= max_cyc) begin
            if (bus_a.o_gen_rst) w_gen_rst++;
            if (bus_a.o_valid && w_first_valid < 0) w_first_valid = k;
            if (bus_a.o_valid && !bus_a.o_locked) w_pre_lock++;
            if (bus_a.o_valid && bus_a.o_locked) w_locked_valid++;
            if (bus_a.o_done) begin
                w_done_seen = 1'b1;
                break;
            end
            if (abort_sym >= 0 && bus_a.o_locked && bus_a.o_sym_cnt == 16'(abort_sym)) begin
                bus_a.i_abort = 1'b1;
                @(negedge clk);
                bus_a.i_abort = 1'b0;
                w_aborted = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int cnt;
        int b_first, b_pre, b_lock_k, b_done_k;

        bus_a.i_start = 1'b0; bus_a.i_abort = 1'b0; bus_a.i_nsym = '0;
        bus_b.i_start = 1'b0; bus_b.i_abort = 1'b0; bus_b.i_nsym = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // ---- reset state ----
        check("rst_busy",      bus_a.o_busy, 0);
        check("rst_valid",     bus_a.o_valid, 0);
        check("rst_gen_rst",   bus_a.o_gen_rst, 0);
        check("rst_locked",    bus_a.o_locked, 0);
        check("rst_done",      bus_a.o_done, 0);
        check("rst_sync_fail", bus_a.o_sync_fail, 0);
        check("rst_err_cnt",   bus_a.o_err_cnt, 0);
        check("rst_sym_cnt",   bus_a.o_sym_cnt, 0);
        rst = 1'b0;

        // ---- clean loopback, nsym=100 ----
        start_a(16'd100);
        check("t1_gen_rst_in_grst", bus_a.o_gen_rst, 1);
        watch_a(3000, -1);
        check("t1_done_reached",  w_done_seen, 1);
        check("t1_gen_rst_len",   w_gen_rst, 1);
        check("t1_first_valid_k", w_first_valid, 6);
        check("t1_ticks_to_lock", w_pre_lock, 25);
        check("t1_run_ticks",     w_locked_valid, 100);
        check("t1_err_cnt",       bus_a.o_err_cnt, 0);
        check("t1_sym_cnt",       bus_a.o_sym_cnt, 100);
        check("t1_locked_done",   bus_a.o_locked, 0);
        check("t1_busy_done",     bus_a.o_busy, 0);

        // ---- one corrupted rx symbol mid-RUN ----
        inject_a = 1'b1;
        start_a(16'd100);
        watch_a(3000, -1);
        inject_a = 1'b0;
        check("t2_done_reached", w_done_seen, 1);
        check("t2_err_cnt",      bus_a.o_err_cnt, 3);
        check("t2_sym_cnt",      bus_a.o_sym_cnt, 100);

        // ---- abort at RUN symbol 50 ----
        start_a(16'd100);
        watch_a(3000, 50);
        check("t3_aborted",  w_aborted, 1);
        check("t3_busy",     bus_a.o_busy, 0);
        check("t3_valid",    bus_a.o_valid, 0);
        check("t3_locked",   bus_a.o_locked, 0);
        check("t3_sym_held", bus_a.o_sym_cnt, 50);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_a.o_valid) cnt++;
        end
        check("t3_valid_stopped", cnt, 0);

        // ---- start and abort together in IDLE ----
        bus_a.i_nsym = 16'd7; bus_a.i_start = 1'b1; bus_a.i_abort = 1'b1;
        @(negedge clk);
        bus_a.i_start = 1'b0; bus_a.i_abort = 1'b0;
        check("t4_busy",     bus_a.o_busy, 0);
        check("t4_gen_rst",  bus_a.o_gen_rst, 0);
        check("t4_sym_held", bus_a.o_sym_cnt, 50);

        // ---- rx stuck at 0 ----
        stuck_a = 1'b1;
        start_a(16'd100);
`ifdef PRBS9_SYNC_TIMEOUT_EN
        watch_a(6000, -1);
        check("t5_done_reached", w_done_seen, 1);
        check("t5_sync_fail",    bus_a.o_sync_fail, 1);
        check("t5_ticks",        w_pre_lock, 9 + 1024);
        check("t5_err_cnt",      bus_a.o_err_cnt, 0);
        check("t5_sym_cnt",      bus_a.o_sym_cnt, 0);
`else
        watch_a(1500, -1);
        check("t5_no_done",   w_done_seen, 0);
        check("t5_locked",    bus_a.o_locked, 0);
        check("t5_busy",      bus_a.o_busy, 1);
        check("t5_sync_fail", bus_a.o_sync_fail, 0);
        check("t5_ticks",     w_pre_lock, 374);
        bus_a.i_abort = 1'b1;
        @(negedge clk);
        bus_a.i_abort = 1'b0;
        check("t5_abort_idle", bus_a.o_busy, 0);
`endif
        stuck_a = 1'b0;

        // ---- async reset in the middle of SYNC ----
        start_a(16'd20);
        cnt = 0;
        for (int i = 0; i < 400 && cnt < 12; i++) begin
            if (bus_a.o_valid) cnt++;
            @(negedge clk);
        end
        check("t6_reached_sync", cnt, 12);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy",    bus_a.o_busy, 0);
        check("t6_rst_valid",   bus_a.o_valid, 0);
        check("t6_rst_gen_rst", bus_a.o_gen_rst, 0);
        check("t6_rst_locked",  bus_a.o_locked, 0);
        @(negedge clk);
        rst = 1'b0;
        start_a(16'd20);
        watch_a(2000, -1);
        check("t6_done_reached",  w_done_seen, 1);
        check("t6_first_valid_k", w_first_valid, 6);
        check("t6_err_cnt",       bus_a.o_err_cnt, 0);
        check("t6_sym_cnt",       bus_a.o_sym_cnt, 20);

        // ---- instance B: DIV=1, nsym=0 ----
        @(negedge clk);
        bus_b.i_nsym = 16'd0; bus_b.i_start = 1'b1;
        @(negedge clk);
        bus_b.i_start = 1'b0;
        b_first = -1; b_pre = 0; b_lock_k = -1; b_done_k = -1;
        for (int k = 1; k <= 200 && b_done_k < 0; k++) begin
            if (bus_b.o_valid && b_first < 0) b_first = k;
            if (bus_b.o_valid && !bus_b.o_locked) b_pre++;
            if (bus_b.o_locked && b_lock_k < 0) b_lock_k = k;
            if (bus_b.o_done) b_done_k = k;
            else @(negedge clk);
        end
        check("t7_first_valid_k",  b_first, 3);
        check("t7_ticks_to_lock",  b_pre, 25);
        check("t7_every_clock",    b_lock_k - b_first, 25);
        check("t7_done_after_run", b_done_k - b_lock_k, 1);
        check("t7_err_cnt",        bus_b.o_err_cnt, 0);
        check("t7_sym_cnt",        bus_b.o_sym_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
